// File: rtl/countdown_timer.sv
`timescale 1ns/1ps
// HH:MM:SS down-counter: loads a clamped preset, counts down on the shared 1 Hz
// tick while running, and latches in EXPIRED once it reaches 00:00:00.
module countdown_timer #(
  parameter int MAX_HOUR = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       TickSec,
  input  logic       Load,
  input  logic [4:0] LoadHour,
  input  logic [5:0] LoadMin,
  input  logic [5:0] LoadSec,
  input  logic       Start,
  input  logic       Stop,
  output logic [4:0] OutHour,
  output logic [5:0] OutMin,
  output logic [5:0] OutSec,
  output logic       Running,
  output logic       Expired,
  output logic       Done,
  output logic       BorrowHour
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] PAUSE   = 2'd2;
  localparam logic [1:0] EXPIRED = 2'd3;

  localparam logic [4:0] MAX_HOUR_V = 5'(MAX_HOUR);
  localparam logic [5:0] MAX_MS     = 6'd59;

  logic [1:0] stateReg, stateNext;
  logic [4:0] hourReg, hourNext;
  logic [5:0] minReg, minNext;
  logic [5:0] secReg, secNext;
  logic       doneReg, doneNext;
  logic       borrowReg, borrowNext;

  logic [4:0] loadHourClamped;
  logic [5:0] loadMinClamped, loadSecClamped;
  logic [4:0] decHour;
  logic [5:0] decMin, decSec;
  logic       decBorrow, decZero, countZero;

  assign loadHourClamped = (LoadHour > MAX_HOUR_V) ? MAX_HOUR_V : LoadHour;
  assign loadMinClamped  = (LoadMin > MAX_MS) ? MAX_MS : LoadMin;
  assign loadSecClamped  = (LoadSec > MAX_MS) ? MAX_MS : LoadSec;

  // One-second borrow chain; only meaningful when the count is nonzero.
  always_comb begin
    decHour   = hourReg;
    decMin    = minReg;
    decSec    = secReg;
    decBorrow = 1'b0;
    if (secReg != 6'd0) begin
      decSec = secReg - 6'd1;
    end else if (minReg != 6'd0) begin
      decSec = MAX_MS;
      decMin = minReg - 6'd1;
    end else begin
      decSec    = MAX_MS;
      decMin    = MAX_MS;
      decHour   = hourReg - 5'd1;
      decBorrow = 1'b1;
    end
  end

  assign decZero   = (decHour == 5'd0) && (decMin == 6'd0) && (decSec == 6'd0);
  assign countZero = (hourReg == 5'd0) && (minReg == 6'd0) && (secReg == 6'd0);

  always_comb begin
    stateNext  = stateReg;
    hourNext   = hourReg;
    minNext    = minReg;
    secNext    = secReg;
    doneNext   = 1'b0;
    borrowNext = 1'b0;
    if (Load) begin
      stateNext = IDLE;
      hourNext  = loadHourClamped;
      minNext   = loadMinClamped;
      secNext   = loadSecClamped;
    end else begin
      case (stateReg)
        IDLE: begin
          if (!Stop && Start && !countZero) stateNext = RUN;
        end
        RUN: begin
          if (Stop) begin
            stateNext = PAUSE;
          end else if (TickSec) begin
            hourNext   = decHour;
            minNext    = decMin;
            secNext    = decSec;
            borrowNext = decBorrow;
            if (decZero) begin
              stateNext = EXPIRED;
              doneNext  = 1'b1;
            end
          end
        end
        PAUSE: begin
          if (!Stop && Start) stateNext = RUN;
        end
        default: begin
          stateNext = EXPIRED;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg  <= IDLE;
      hourReg   <= 5'd0;
      minReg    <= 6'd0;
      secReg    <= 6'd0;
      doneReg   <= 1'b0;
      borrowReg <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      hourReg   <= hourNext;
      minReg    <= minNext;
      secReg    <= secNext;
      doneReg   <= doneNext;
      borrowReg <= borrowNext;
    end
  end

  assign OutHour    = hourReg;
  assign OutMin     = minReg;
  assign OutSec     = secReg;
  assign Running    = (stateReg == RUN);
  assign Expired    = (stateReg == EXPIRED);
  assign Done       = doneReg;
  assign BorrowHour = borrowReg;

endmodule

// File: tb/tb_countdown_timer.sv
`timescale 1ns/1ps
// Bench for countdown_timer: directed vector table, async-reset sequence, and
// randomized traffic checked against a total-seconds reference model.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       TickSec, Load, Start, Stop;
  logic [4:0] LoadHour;
  logic [5:0] LoadMin, LoadSec;
  logic [4:0] OutHour;
  logic [5:0] OutMin, OutSec;
  logic       Running, Expired, Done, BorrowHour;

  countdown_timer #(.MAX_HOUR(23)) dut (
    .clk(clk), .reset(reset), .TickSec(TickSec), .Load(Load),
    .LoadHour(LoadHour), .LoadMin(LoadMin), .LoadSec(LoadSec),
    .Start(Start), .Stop(Stop),
    .OutHour(OutHour), .OutMin(OutMin), .OutSec(OutSec),
    .Running(Running), .Expired(Expired), .Done(Done), .BorrowHour(BorrowHour)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [4:0] lh;
    logic [5:0] lm, ls;
    logic       st, sp, tk;
    logic [4:0] eh;
    logic [5:0] em, es;
    logic       er, ex, dn, bh;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int fails  = 0;

  function automatic vec_t mk(input logic ld, input int lh, input int lm, input int ls,
                              input logic st, input logic sp, input logic tk,
                              input int eh, input int em, input int es,
                              input logic er, input logic ex, input logic dn, input logic bh);
    vec_t v;
    v.ld = ld; v.lh = 5'(lh); v.lm = 6'(lm); v.ls = 6'(ls);
    v.st = st; v.sp = sp; v.tk = tk;
    v.eh = 5'(eh); v.em = 6'(em); v.es = 6'(es);
    v.er = er; v.ex = ex; v.dn = dn; v.bh = bh;
    return v;
  endfunction

  task automatic checkOut(input string name, input logic [20:0] exp);
    logic [20:0] act;
    act = {OutHour, OutMin, OutSec, Running, Expired, Done, BorrowHour};
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d:%0d:%0d R%b E%b D%b B%b, expected %0d:%0d:%0d R%b E%b D%b B%b",
               name, act[20:16], act[15:10], act[9:4], act[3], act[2], act[1], act[0],
               exp[20:16], exp[15:10], exp[9:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic step(input logic ld, input logic [4:0] lh, input logic [5:0] lm,
                      input logic [5:0] ls, input logic st, input logic sp, input logic tk);
    Load = ld; LoadHour = lh; LoadMin = lm; LoadSec = ls;
    Start = st; Stop = sp; TickSec = tk;
    @(posedge clk);
    #1;
    Load = 1'b0; Start = 1'b0; Stop = 1'b0; TickSec = 1'b0;
  endtask

  initial begin
    int mTotal, mState, oldHour;
    logic mDone, mBorrow;
    logic rLd, rSt, rSp, rTk;
    logic [4:0] rLh;
    logic [5:0] rLm, rLs;
    int sel, hh, mm, ss;

    reset = 1'b1;
    Load = 1'b0; Start = 1'b0; Stop = 1'b0; TickSec = 1'b0;
    LoadHour = '0; LoadMin = '0; LoadSec = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOut("reset state", 21'd0);
    reset = 1'b0;

    //          ld lh lm ls st sp tk   eh em es er ex dn bh
    vecs.push_back(mk(1, 0, 0, 3, 0, 0, 0,  0, 0, 3, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 3, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 2, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,  1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 59, 59, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 59, 59, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,  0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 59, 1, 0, 0, 0));
    vecs.push_back(mk(1, 31, 63, 60, 0, 0, 0, 23, 59, 59, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 10, 0, 0, 0, 0, 0, 10, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 10, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1,  0, 0, 10, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 10, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 10, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 10, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 9, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 9, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1,  0, 0, 9, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 5, 0, 0, 0, 1,  0, 5, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 5, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].ld, vecs[i].lh, vecs[i].lm, vecs[i].ls, vecs[i].st, vecs[i].sp, vecs[i].tk);
      $display("vec %0d: ld=%b st=%b sp=%b tk=%b -> %0d:%0d:%0d R%b E%b D%b B%b",
               i, vecs[i].ld, vecs[i].st, vecs[i].sp, vecs[i].tk,
               OutHour, OutMin, OutSec, Running, Expired, Done, BorrowHour);
      checkOut($sformatf("vec%0d", i),
               {vecs[i].eh, vecs[i].em, vecs[i].es, vecs[i].er, vecs[i].ex, vecs[i].dn, vecs[i].bh});
    end

    // Asynchronous reset in the middle of a running count.
    step(1'b1, 5'd12, 6'd34, 6'd56, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0);
    checkOut("run at 12:34:56", {5'd12, 6'd34, 6'd56, 1'b1, 1'b0, 1'b0, 1'b0});
    #2 reset = 1'b1;
    #1;
    $display("async reset asserted between edges -> %0d:%0d:%0d R%b", OutHour, OutMin, OutSec, Running);
    checkOut("async reset before edge", 21'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1);
      checkOut($sformatf("post-reset tick %0d", k), 21'd0);
    end
    step(1'b1, 5'd0, 6'd0, 6'd2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1);
    checkOut("post-reset resume", {5'd0, 6'd0, 6'd1, 1'b1, 1'b0, 1'b0, 1'b0});

    // Randomized traffic against a total-seconds model (0 idle, 1 run, 2 pause, 3 expired).
    mTotal = 0;
    mState = 0;
    for (int i = 0; i < 1200; i++) begin
      rLd = (i == 0) || ($urandom_range(15, 0) == 0);
      sel = int'($urandom_range(2, 0));
      if (sel == 0) begin
        rLh = 5'd0; rLm = 6'($urandom_range(1, 0)); rLs = 6'($urandom_range(4, 0));
      end else if (sel == 1) begin
        rLh = 5'($urandom_range(2, 1)); rLm = 6'd0; rLs = 6'($urandom_range(2, 0));
      end else begin
        rLh = 5'($urandom_range(31, 0)); rLm = 6'($urandom_range(63, 0)); rLs = 6'($urandom_range(63, 0));
      end
      rSt = ($urandom_range(7, 0) == 0);
      rSp = !rSt && ($urandom_range(15, 0) == 0);
      rTk = ($urandom_range(1, 0) == 1);

      mDone = 1'b0;
      mBorrow = 1'b0;
      if (rLd) begin
        hh = (int'(rLh) > 23) ? 23 : int'(rLh);
        mm = (int'(rLm) > 59) ? 59 : int'(rLm);
        ss = (int'(rLs) > 59) ? 59 : int'(rLs);
        mTotal = hh * 3600 + mm * 60 + ss;
        mState = 0;
      end else if (mState == 0) begin
        if (rSt && mTotal > 0) mState = 1;
      end else if (mState == 1) begin
        if (rSp) begin
          mState = 2;
        end else if (rTk) begin
          oldHour = mTotal / 3600;
          mTotal = mTotal - 1;
          mBorrow = (mTotal / 3600) != oldHour;
          if (mTotal == 0) begin
            mState = 3;
            mDone = 1'b1;
          end
        end
      end else if (mState == 2) begin
        if (rSt) mState = 1;
      end

      step(rLd, rLh, rLm, rLs, rSt, rSp, rTk);
      $display("rnd %0d: ld=%b %0d:%0d:%0d st=%b sp=%b tk=%b -> %0d:%0d:%0d R%b E%b D%b B%b",
               i, rLd, rLh, rLm, rLs, rSt, rSp, rTk,
               OutHour, OutMin, OutSec, Running, Expired, Done, BorrowHour);
      checkOut($sformatf("rnd%0d", i),
               {5'(mTotal / 3600), 6'((mTotal / 60) % 60), 6'(mTotal % 60),
                mState == 1, mState == 3, mDone, mBorrow});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
